// File: rtl/iomem_interconnect.sv
// iomem_interconnect: routes the picosoc iomem master port to up to NSLOTS
// memory-mapped peripherals. The target slot is latched per transaction, read data
// is muxed by that latched slot, a watchdog completes stalled accesses, and an
// internal status block records timeouts and unmapped accesses.
//
// Ports:
//   clk, resetn            system clock, synchronous active-low reset
//   iomem_valid/wstrb/addr/wdata   master request (wstrb == 0 means read)
//   iomem_ready, iomem_rdata       one-cycle completion pulse and its read data
//   s_valid, s_ready, s_rdata      per-slot request / completion / read data lanes
//   s_wstrb, s_addr, s_wdata       master signals broadcast to every slot
//   err_irq                        level interrupt: timeout or unmapped sticky set
module iomem_interconnect #(
    parameter int unsigned         NSLOTS      = 8,
    parameter logic [NSLOTS*8-1:0] SLOT_BASE   = 64'h0A09_0807_0605_0403,
    parameter logic [7:0]          STATUS_BASE = 8'h0F,
    parameter int unsigned         TIMEOUT     = 1024,
    parameter logic [31:0]         ERR_RDATA   = 32'hFFFF_FFFF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   iomem_valid,
    input  logic [3:0]             iomem_wstrb,
    input  logic [31:0]            iomem_addr,
    input  logic [31:0]            iomem_wdata,
    output logic                   iomem_ready,
    output logic [31:0]            iomem_rdata,
    output logic [NSLOTS-1:0]      s_valid,
    input  logic [NSLOTS-1:0]      s_ready,
    input  logic [NSLOTS*32-1:0]   s_rdata,
    output logic [3:0]             s_wstrb,
    output logic [31:0]            s_addr,
    output logic [31:0]            s_wdata,
    output logic                   err_irq
);

    localparam int unsigned SelW  = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
    // A disabled watchdog still gets a 1-bit counter so the logic stays well formed.
    localparam int unsigned WdogW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WdogW-1:0] WdogLast = WdogW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit WdogEn = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic [WdogW-1:0]  wdog_q, wdog_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              timeout_q, timeout_d;
    logic              unmapped_q, unmapped_d;
    logic [3:0]        err_slot_q, err_slot_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [31:0]       err_addr_q, err_addr_d;

    logic [31:0]       slot_rdata [NSLOTS];
    logic [NSLOTS-1:0] slot_match;
    logic              slot_hit;
    logic [SelW-1:0]   slot_idx;
    logic              status_hit;
    logic [31:0]       status_word0;
    logic              log_err;
    logic [3:0]        log_slot;

    for (genvar g = 0; g < NSLOTS; g++) begin : g_slot
        assign slot_rdata[g] = s_rdata[32*g +: 32];
        assign slot_match[g] = (iomem_addr[31:24] == SLOT_BASE[8*g +: 8]);
    end

    // Scan from the top so that the lowest matching index is the one that sticks.
    always_comb begin
        slot_hit = 1'b0;
        slot_idx = '0;
        for (int i = int'(NSLOTS) - 1; i >= 0; i--) begin
            if (slot_match[i]) begin
                slot_hit = 1'b1;
                slot_idx = SelW'(i);
            end
        end
    end

    assign status_hit   = (iomem_addr[31:24] == STATUS_BASE);
    assign status_word0 = {err_cnt_q, 4'h0, err_slot_q, 6'h0, unmapped_q, timeout_q};

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        wdog_d     = wdog_q;
        rdata_d    = rdata_q;
        timeout_d  = timeout_q;
        unmapped_d = unmapped_q;
        err_slot_d = err_slot_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        log_err    = 1'b0;
        log_slot   = 4'h0;
        s_valid    = '0;

        case (state_q)
            StIdle: begin
                if (iomem_valid) begin
                    if (slot_hit) begin
                        sel_d   = slot_idx;
                        wdog_d  = '0;
                        state_d = StWait;
                    end else if (status_hit) begin
                        // Reads see the pre-clear register contents.
                        rdata_d = iomem_addr[2] ? err_addr_q : status_word0;
                        if (iomem_wstrb != 4'h0 && !iomem_addr[2]) begin
                            timeout_d  = 1'b0;
                            unmapped_d = 1'b0;
                            err_cnt_d  = '0;
                            err_slot_d = '0;
                        end
                        state_d = StResp;
                    end else begin
                        unmapped_d = 1'b1;
                        rdata_d    = '0;
                        log_err    = 1'b1;
                        log_slot   = 4'hF;
                        state_d    = StResp;
                    end
                end
            end
            StWait: begin
                s_valid[sel_q] = iomem_valid;
                if (!iomem_valid) begin
                    // Master withdrew the request: drop it without a response.
                    state_d = StIdle;
                end else if (s_ready[sel_q]) begin
                    // Ready is checked first so it wins over a simultaneous expiry.
                    rdata_d = slot_rdata[sel_q];
                    state_d = StResp;
                end else if (WdogEn && wdog_q == WdogLast) begin
                    rdata_d   = ERR_RDATA;
                    timeout_d = 1'b1;
                    log_err   = 1'b1;
                    log_slot  = 4'(sel_q);
                    state_d   = StResp;
                end else begin
                    wdog_d = wdog_q + WdogW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (log_err) begin
            err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
            err_addr_d = iomem_addr;
            err_slot_d = log_slot;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            wdog_q     <= '0;
            rdata_q    <= '0;
            timeout_q  <= 1'b0;
            unmapped_q <= 1'b0;
            err_slot_q <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            wdog_q     <= wdog_d;
            rdata_q    <= rdata_d;
            timeout_q  <= timeout_d;
            unmapped_q <= unmapped_d;
            err_slot_q <= err_slot_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign iomem_ready = (state_q == StResp);
    assign iomem_rdata = rdata_q;
    assign s_wstrb     = iomem_wstrb;
    assign s_addr      = iomem_addr;
    assign s_wdata     = iomem_wdata;
    assign err_irq     = timeout_q | unmapped_q;

endmodule

// File: tb/tb_iomem_interconnect.sv
// Randomised scoreboard bench for iomem_interconnect. The driver computes each
// transaction's expected read data and completion cycle from a transaction-level
// model of the status block and pushes it into a queue; a monitor pops and compares
// whenever iomem_ready is seen.
module tb_iomem_interconnect;

    localparam int NS  = 8;
    localparam int TMO = 16;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic              clk;
    logic              resetn;
    logic              iomem_valid;
    logic [3:0]        iomem_wstrb;
    logic [31:0]       iomem_addr;
    logic [31:0]       iomem_wdata;
    logic              iomem_ready;
    logic [31:0]       iomem_rdata;
    logic [NS-1:0]     s_valid;
    logic [NS-1:0]     s_ready;
    logic [NS*32-1:0]  s_rdata;
    logic [3:0]        s_wstrb;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic              err_irq;

    iomem_interconnect #(
        .TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .iomem_valid(iomem_valid),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_ready(iomem_ready),
        .iomem_rdata(iomem_rdata),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_rdata    (s_rdata),
        .s_wstrb    (s_wstrb),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .err_irq    (err_irq)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    // Reference model of the status block.
    logic        m_to, m_un;
    logic [3:0]  m_slot;
    logic [15:0] m_cnt;
    logic [31:0] m_addr;

    logic [7:0] unm_tops [4] = '{8'h00, 8'h0B, 8'h0C, 8'hFF};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endfunction

    function automatic void model_reset();
        m_to = 1'b0; m_un = 1'b0; m_slot = 4'h0; m_cnt = 16'h0; m_addr = 32'h0;
    endfunction

    function automatic void model_log(input logic [3:0] slot, input logic [31:0] addr);
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_slot = slot;
        m_addr = addr;
    endfunction

    // Default slot bases are 0x03..0x0A, so slot index is simply top byte minus 3.
    function automatic int slot_of(input logic [31:0] addr);
        if (addr[31:24] >= 8'h03 && addr[31:24] <= 8'h0A) return int'(addr[31:24]) - 3;
        return -1;
    endfunction

    // k: cycle in which the slot raises ready (0 = held high, > TMO = never).
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb, input int k,
                           input logic [31:0] sdata);
        exp_t          e;
        int            slot, lat, keff, j;
        logic [NS-1:0] oh;
        logic [31:0]   wd;
        bit            ok;
        @(negedge clk);
        slot = slot_of(addr);
        wd   = $urandom;
        oh   = '0;
        if (slot >= 0) begin
            oh[slot] = 1'b1;
            keff = (k < 1) ? 1 : k;
            if (keff <= TMO) begin
                lat     = keff + 1;
                e.rdata = sdata;
            end else begin
                lat     = TMO + 1;
                e.rdata = 32'hFFFF_FFFF;
                m_to    = 1'b1;
                model_log(4'(slot), addr);
            end
        end else if (addr[31:24] == 8'h0F) begin
            lat     = 1;
            e.rdata = addr[2] ? m_addr : {m_cnt, 4'h0, m_slot, 6'h0, m_un, m_to};
            if (wstrb != 4'h0 && !addr[2]) begin
                m_to = 1'b0; m_un = 1'b0; m_slot = 4'h0; m_cnt = 16'h0;
            end
        end else begin
            lat     = 1;
            e.rdata = 32'h0;
            m_un    = 1'b1;
            model_log(4'hF, addr);
        end
        e.cyc = cyc + lat;
        exp_q.push_back(e);

        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = wstrb;
        iomem_wdata = wd;
        for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = (i == slot) ? sdata : $urandom;
        s_ready = NS'($urandom) & ~oh;
        if (slot >= 0 && k == 0) s_ready = s_ready | oh;

        j  = 0;
        ok = 1'b1;
        while (1) begin
            @(negedge clk);
            j++;
            if (j == 1 && (s_addr !== addr || s_wdata !== wd || s_wstrb !== wstrb)) ok = 1'b0;
            if (iomem_ready) begin
                if (s_valid !== '0) ok = 1'b0;
                iomem_valid = 1'b0;
                s_ready     = '0;
                break;
            end
            if (j > 4 * TMO + 20) begin
                check("ready_within_bound", iomem_ready, 1);
                iomem_valid = 1'b0;
                s_ready     = '0;
                break;
            end
            if (s_valid !== oh) ok = 1'b0;
            for (int i = 0; i < NS; i++) if (i != slot) s_rdata[32*i +: 32] = $urandom;
            s_ready = NS'($urandom) & ~oh;
            if (slot >= 0 && (k == 0 || j == k)) s_ready = s_ready | oh;
        end
        check("slot_strobes", ok, 1);
        check("err_irq", err_irq, m_to | m_un);
    endtask

    task automatic abort_txn(input logic [31:0] addr);
        logic [NS-1:0] oh;
        oh = '0;
        oh[slot_of(addr)] = 1'b1;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = 4'h0;
        s_ready     = '0;
        repeat (3) @(negedge clk);
        check("abort_pre_s_valid", s_valid, oh);
        iomem_valid = 1'b0;
        @(negedge clk);
        check("abort_s_valid", s_valid, 0);
        check("abort_ready", iomem_ready, 0);
        @(negedge clk);
        check("abort_ready_late", iomem_ready, 0);
        check("abort_irq", err_irq, m_to | m_un);
    endtask

    task automatic reset_in_wait(input logic [31:0] addr);
        logic [NS-1:0] oh;
        oh = '0;
        oh[slot_of(addr)] = 1'b1;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = 4'h0;
        s_ready     = '0;
        repeat (2) @(negedge clk);
        check("pre_reset_s_valid", s_valid, oh);
        resetn = 1'b0;
        @(negedge clk);
        model_reset();
        check("rst_wait_s_valid", s_valid, 0);
        check("rst_wait_ready", iomem_ready, 0);
        check("rst_wait_rdata", iomem_rdata, 0);
        check("rst_wait_irq", err_irq, 0);
        iomem_valid = 1'b0;
        resetn      = 1'b1;
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (iomem_ready) begin
                check("pending_txn", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rdata", iomem_rdata, e.rdata);
                    check("ready_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int          r, k;
        logic [7:0]  top;
        logic [3:0]  ws;
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        s_ready     = '0;
        s_rdata     = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_ready", iomem_ready, 0);
        check("reset_rdata", iomem_rdata, 0);
        check("reset_s_valid", s_valid, 0);
        check("reset_irq", err_irq, 0);
        resetn = 1'b1;
        run_txn(32'h0F00_0000, 4'h0, 0, 32'h0);
        run_txn(32'h0F00_0004, 4'h0, 0, 32'h0);

        // Slot 2 read, ready three cycles after s_valid.
        run_txn(32'h0500_0000, 4'h0, 3, 32'h1234_5678);
        // Unmapped write, then both status words.
        run_txn(32'h0B00_0000, 4'hF, 0, 32'h0);
        run_txn(32'h0F00_0000, 4'h0, 0, 32'h0);
        run_txn(32'h0F00_0004, 4'h0, 0, 32'h0);
        // Slot 0 never ready: watchdog expiry.
        run_txn(32'h0300_0010, 4'h0, 999, $urandom);
        run_txn(32'h0F00_0000, 4'h0, 0, 32'h0);
        // Ready exactly on the expiry cycle.
        run_txn(32'h0300_0020, 4'h0, TMO, 32'hCAFE_F00D);
        run_txn(32'h0F00_0000, 4'h0, 0, 32'h0);
        // Clear through word 0, word 1 keeps the last error address.
        run_txn(32'h0F00_0000, 4'hF, 0, 32'h0);
        run_txn(32'h0F00_0000, 4'h0, 0, 32'h0);
        run_txn(32'h0F00_0004, 4'hF, 0, 32'h0);
        run_txn(32'h0F00_0004, 4'h0, 0, 32'h0);
        // Reset while waiting, after an error that set rdata and the irq.
        run_txn(32'h0A00_0000, 4'h0, 999, $urandom);
        reset_in_wait(32'h0400_0000);
        run_txn(32'h0400_0000, 4'h0, 2, $urandom);
        run_txn(32'h0F00_0000, 4'h0, 0, 32'h0);
        // Master withdraws mid-wait.
        abort_txn(32'h0600_0000);
        run_txn(32'h0F00_0000, 4'h0, 0, 32'h0);
        run_txn(32'h0700_0000, 4'h3, 0, $urandom);

        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 9);
            ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            k  = $urandom_range(0, 6);
            if (r <= 5) begin
                top = 8'h03 + 8'($urandom_range(0, 7));
                if ($urandom_range(0, 7) == 0) k = 999;
                else if ($urandom_range(0, 7) == 0) k = TMO;
            end else if (r <= 7) begin
                top = unm_tops[$urandom_range(0, 3)];
            end else begin
                top = 8'h0F;
                if ($urandom_range(0, 3) != 0) ws = 4'h0;
            end
            run_txn({top, 24'($urandom)}, ws, k, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iomem_interconnect.md
# iomem_interconnect

Parametrised peripheral-bus interconnect between the picosoc `iomem_*` master port and up to NSLOTS memory-mapped peripherals. It replaces hand-written enable/ready/rdata muxing in the top level. It latches the target slot per transaction and muxes read data by the latched slot, not by ready. A bus watchdog completes stalled transactions, and a status register records timeouts and unmapped accesses and drives an interrupt.

## Interface
Parameters:
- NSLOTS, 8, number of peripheral slots (1..16).
- SLOT_BASE, 64'h0A09_0807_0605_0403, packed NSLOTS×8 bits; slot i decodes `iomem_addr[31:24] == SLOT_BASE[8i+7:8i]`.
- STATUS_BASE, 8'h0F, `addr[31:24]` of the internal status register block.
- TIMEOUT, 1024, cycles in WAIT before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'hFFFF_FFFF, rdata returned on a timed-out access.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- iomem_valid  in  1  master request.
- iomem_wstrb  in  4  master write strobes; 0 means read.
- iomem_addr  in  32  master address.
- iomem_wdata  in  32  master write data.
- iomem_ready  out  1  one-cycle completion pulse.
- iomem_rdata  out  32  read data, valid while iomem_ready = 1.
- s_valid  out  NSLOTS  per-slot request; one-hot or zero.
- s_ready  in  NSLOTS  per-slot completion.
- s_rdata  in  NSLOTS×32  slot i occupies bits [32i+31:32i].
- s_wstrb / s_addr / s_wdata  out  4/32/32  combinational copies of the master signals, shared by all slots.
- err_irq  out  1  level: timeout_sticky OR unmapped_sticky.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE, iomem_valid = 1: decode `addr[31:24]`. If several slots share a base, the lowest index wins.
  - Slot hit: latch sel, clear wdog, go to WAIT.
  - STATUS_BASE hit: perform the status access, go to RESP.
  - No hit: set unmapped_sticky, log the error, go to RESP with rdata = 0.
- WAIT:
  - `s_valid[sel] = iomem_valid`; all other s_valid bits are 0. s_valid is 0 in IDLE and RESP.
  - `s_ready[sel]` = 1: register `s_rdata[sel]` into iomem_rdata, go to RESP.
  - Else, if TIMEOUT ≠ 0 and wdog == TIMEOUT−1: rdata = ERR_RDATA, set timeout_sticky, log the error, go to RESP.
  - Else wdog increments.
  - If iomem_valid drops while in WAIT: abort to IDLE, no iomem_ready, no logging.
- RESP: iomem_ready = 1 for exactly one cycle, then IDLE.
- Status block, selected by `addr[2]`:
  - Word 0: bit0 timeout_sticky, bit1 unmapped_sticky, [11:8] last error slot (0xF = unmapped), [31:16] error count, saturating at 0xFFFF.
  - Word 1: last error address.
  - A write (wstrb ≠ 0) to word 0 clears both stickies, the count and the slot field. Writes to word 1 are ignored.
  - Reads return the values held before any update in the same cycle.
- "Log the error" means: count +1 (saturating), capture the error address and the slot field.
- Width rule: wdog is `$clog2(TIMEOUT+1)` bits.

## Timing
- Reset (resetn low at a clk edge):
  - state = IDLE.
  - iomem_ready = 0, iomem_rdata = 0, s_valid = 0, err_irq = 0.
  - Stickies, count, slot field and error address are all 0.
  - Reset mid-transaction drops it silently.
- Slot access: valid at cycle 0, s_valid from cycle 1, s_ready at cycle k ≥ 1, iomem_ready at cycle k+1. Minimum latency is 2 cycles.
- Status access and unmapped access: iomem_ready at cycle 1.
- A slot that holds ready permanently high completes in 2 cycles.
- Timeout with no ready: iomem_ready at cycle TIMEOUT+1.
- s_ready on the same edge as wdog expiry: ready wins, no error is logged.
- err_irq updates on the same edge the sticky bit is set.
- A new request is accepted in the cycle after RESP at the earliest.

## Test plan
- Read slot 2 (addr 0x0500_0000), s_ready[2] asserted 3 cycles after s_valid, rdata 0x1234_5678 -> s_valid = 0b100 for 3 cycles; iomem_ready 1 cycle later with 0x1234_5678; no errors.
- Write to 0x0B00_0000 (unmapped) -> iomem_ready at cycle 1, rdata 0, unmapped_sticky = 1, err_irq = 1, word0 = 0x0001_0F02, word1 = 0x0B00_0000.
- TIMEOUT = 16, slot 0 never ready -> iomem_ready at cycle 17 with 0xFFFF_FFFF; timeout_sticky = 1; slot field = 0.
- s_ready asserted exactly on the expiry cycle -> slot rdata returned; word0 unchanged.
- Write 0 to 0x0F00_0000 after errors -> word0 reads 0, err_irq = 0; word1 still holds the last error address.
- resetn pulsed low while in WAIT -> next cycle state IDLE, s_valid = 0, iomem_ready stays 0; the next access completes normally.
